// File: rtl/tamagotchi_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : tamagotchi_core_if
//  Description : Board-side bundle for the pet engine: raw active-low buttons
//                and sensors in, mood/level/status outputs towards the
//                display/sprite driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface tamagotchi_core_if #(
    parameter int LVL_W = 3
);
    logic             test_n;
    logic             feed_n;
    logic             play_n;
    logic             ultrasonido_n;
    logic             ruido_n;
    logic [2:0]       estado;
    logic [LVL_W-1:0] hambre;
    logic [LVL_W-1:0] diversion;
    logic             tick;
    logic             estado_cambio;
    logic             test_active;

    // Board / display side: drives raw pins, consumes mood and levels
    modport master (
        output test_n, feed_n, play_n, ultrasonido_n, ruido_n,
        input  estado, hambre, diversion, tick, estado_cambio, test_active
    );

    // Pet engine side
    modport slave (
        input  test_n, feed_n, play_n, ultrasonido_n, ruido_n,
        output estado, hambre, diversion, tick, estado_cambio, test_active
    );
endinterface
`default_nettype wire

// File: rtl/tamagotchi_core.sv
`default_nettype none
// ============================================================================
//  Module      : tamagotchi_core
//  Description : Pet-behaviour engine. Owns hunger/fun levels (decay, feed,
//                play), synchronises raw inputs, evaluates mood once per tick,
//                tracks sustained-critical death and a held-button test mode.
//  Revision    : 1.0  initial release
// ============================================================================
module tamagotchi_core #(
    parameter int TICK_CYCLES     = 50_000_000,
    parameter int LVL_W           = 3,
    parameter int LVL_MAX         = 5,
    parameter int HUNGRY_TH       = 4,
    parameter int SAD_TH          = 2,
    parameter int HAPPY_TH        = 4,
    parameter int DECAY_TICKS     = 10,
    parameter int TIRED_TICKS     = 3,
    parameter int DEATH_TICKS     = 20,
    parameter int TEST_HOLD_TICKS = 5
) (
    input  logic              clk,
    input  logic              reset,
    tamagotchi_core_if.slave  bus
);

    // Mood codes
    localparam logic [2:0] c_NEUTRO     = 3'd0;
    localparam logic [2:0] c_FELIZ      = 3'd1;
    localparam logic [2:0] c_TRISTE     = 3'd2;
    localparam logic [2:0] c_CANSADO    = 3'd3;
    localparam logic [2:0] c_HAMBRIENTO = 3'd4;
    localparam logic [2:0] c_MUERTO     = 3'd5;

    // Counter widths
    localparam int TCW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DCW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam int RCW = $clog2(TIRED_TICKS + 1);
    localparam int CCW = $clog2(DEATH_TICKS + 1);
    localparam int HCW = $clog2(TEST_HOLD_TICKS + 1);
    localparam int LW2 = LVL_W + 2;

    localparam logic [TCW-1:0] c_TICK_LAST  = TCW'(TICK_CYCLES - 1);
    localparam logic [DCW-1:0] c_DECAY_LAST = DCW'(DECAY_TICKS - 1);
    localparam logic [RCW-1:0] c_TIRED      = RCW'(TIRED_TICKS);
    localparam logic [RCW-1:0] c_TIRED_M1   = RCW'(TIRED_TICKS - 1);
    localparam logic [CCW-1:0] c_DEATH      = CCW'(DEATH_TICKS);
    localparam logic [CCW-1:0] c_DEATH_M1   = CCW'(DEATH_TICKS - 1);
    localparam logic [HCW-1:0] c_HOLD       = HCW'(TEST_HOLD_TICKS);
    localparam logic [HCW-1:0] c_HOLD_M1    = HCW'(TEST_HOLD_TICKS - 1);

    localparam logic [LVL_W-1:0] c_LVL_MAX   = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] c_LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] c_LVL_TWO   = LVL_W'(2);
    localparam logic [LVL_W-1:0] c_HUNGRY_TH = LVL_W'(HUNGRY_TH);
    localparam logic [LVL_W-1:0] c_SAD_TH    = LVL_W'(SAD_TH);
    localparam logic [LVL_W-1:0] c_HAPPY_TH  = LVL_W'(HAPPY_TH);

    localparam logic signed [LW2-1:0] c_S_ZERO = '0;
    localparam logic signed [LW2-1:0] c_S_ONE  = LW2'(1);
    localparam logic signed [LW2-1:0] c_S_TWO  = LW2'(2);
    localparam logic signed [LW2-1:0] c_S_MAX  = LW2'(LVL_MAX);

    // Synchroniser bit order: 0 test, 1 feed, 2 play, 3 ultrasound, 4 noise
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [1:0]       r_btn_prev;
    logic [TCW-1:0]   r_tick_cnt;
    logic [DCW-1:0]   r_decay_cnt;
    logic [RCW-1:0]   r_tired_cnt;
    logic [CCW-1:0]   r_crit_cnt;
    logic [HCW-1:0]   r_hold_cnt;
    logic [LVL_W-1:0] r_hambre;
    logic [LVL_W-1:0] r_diversion;
    logic [2:0]       r_estado;
    logic             r_estado_cambio;
    logic             r_test_active;

    logic                  w_tick;
    logic                  w_decay;
    logic                  w_feed;
    logic                  w_play;
    logic                  w_test_rel;
    logic                  w_sensor;
    logic                  w_crit;
    logic                  w_frozen;
    logic                  w_test_exit;
    logic signed [LW2-1:0] w_h_sum;
    logic signed [LW2-1:0] w_d_sum;
    logic [LVL_W-1:0]      w_h_nxt;
    logic [LVL_W-1:0]      w_d_nxt;
    logic [2:0]            w_estado_nxt;
    logic                  w_test_nxt;

    assign w_tick      = (r_tick_cnt == c_TICK_LAST);
    assign w_decay     = w_tick && (r_decay_cnt == c_DECAY_LAST);
    assign w_feed      = r_btn_prev[0] & ~r_sync2[1];
    assign w_play      = r_btn_prev[1] & ~r_sync2[2];
    assign w_test_rel  = r_sync2[0];
    assign w_sensor    = ~r_sync2[3] | ~r_sync2[4];
    assign w_crit      = (r_hambre == c_LVL_MAX) || (r_diversion == c_LVL_ONE);
    assign w_frozen    = (r_estado == c_MUERTO) || r_test_active;
    assign w_test_exit = r_test_active && w_test_rel;

    // Two-flop synchronisers plus previous-value register for press edges
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_btn_prev <= '1;
        end else begin
            r_sync1    <= {bus.ruido_n, bus.ultrasonido_n, bus.play_n,
                           bus.feed_n, bus.test_n};
            r_sync2    <= r_sync1;
            r_btn_prev <= r_sync2[2:1];
        end
    end

    // Tick period counter and decay-interval counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt  <= '0;
            r_decay_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TCW'(1);
            if (w_tick)
                r_decay_cnt <= w_decay ? '0 : r_decay_cnt + DCW'(1);
        end
    end

    // All level events in a cycle are summed before clamping to [1, LVL_MAX]
    always_comb begin
        w_h_sum = $signed({2'b00, r_hambre})
                + (w_decay ? c_S_ONE : c_S_ZERO)
                - (w_feed  ? c_S_TWO : c_S_ZERO);
        w_d_sum = $signed({2'b00, r_diversion})
                - (w_decay ? c_S_ONE : c_S_ZERO)
                + (w_play  ? c_S_TWO : c_S_ZERO);
        if (w_h_sum < c_S_ONE)
            w_h_nxt = c_LVL_ONE;
        else if (w_h_sum > c_S_MAX)
            w_h_nxt = c_LVL_MAX;
        else
            w_h_nxt = w_h_sum[LVL_W-1:0];
        if (w_d_sum < c_S_ONE)
            w_d_nxt = c_LVL_ONE;
        else if (w_d_sum > c_S_MAX)
            w_d_nxt = c_LVL_MAX;
        else
            w_d_nxt = w_d_sum[LVL_W-1:0];
    end

    // Level registers; frozen (presses ignored) when dead or in test mode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hambre    <= c_LVL_ONE;
            r_diversion <= c_LVL_MAX;
        end else if (!w_frozen) begin
            r_hambre    <= w_h_nxt;
            r_diversion <= w_d_nxt;
        end
    end

    // Tired, critical and test-hold counters; test exit wipes them all
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tired_cnt <= '0;
            r_crit_cnt  <= '0;
            r_hold_cnt  <= '0;
        end else if (w_test_exit) begin
            r_tired_cnt <= '0;
            r_crit_cnt  <= '0;
            r_hold_cnt  <= '0;
        end else begin
            if (w_test_rel)
                r_hold_cnt <= '0;
            else if (w_tick && (r_hold_cnt != c_HOLD))
                r_hold_cnt <= r_hold_cnt + HCW'(1);
            if (w_tick) begin
                if (!w_sensor)
                    r_tired_cnt <= '0;
                else if (r_tired_cnt != c_TIRED)
                    r_tired_cnt <= r_tired_cnt + RCW'(1);
                if (!w_crit)
                    r_crit_cnt <= '0;
                else if (r_crit_cnt != c_DEATH)
                    r_crit_cnt <= r_crit_cnt + CCW'(1);
            end
        end
    end

    // Next mood: test exit is immediate, everything else happens on a tick
    always_comb begin
        w_estado_nxt = r_estado;
        w_test_nxt   = r_test_active;
        if (w_test_exit) begin
            w_estado_nxt = c_NEUTRO;
            w_test_nxt   = 1'b0;
        end else if (w_tick) begin
            if (r_estado > c_MUERTO)
                w_estado_nxt = c_NEUTRO;
            else if (r_test_active)
                w_estado_nxt = (r_estado == c_MUERTO) ? c_NEUTRO
                                                      : r_estado + 3'd1;
            else if (r_estado == c_MUERTO)
                w_estado_nxt = c_MUERTO;
            else if (w_crit && (r_crit_cnt >= c_DEATH_M1))
                w_estado_nxt = c_MUERTO;
            else if (r_hambre >= c_HUNGRY_TH)
                w_estado_nxt = c_HAMBRIENTO;
            else if (w_sensor && (r_tired_cnt >= c_TIRED_M1))
                w_estado_nxt = c_CANSADO;
            else if (r_diversion <= c_SAD_TH)
                w_estado_nxt = c_TRISTE;
            else if ((r_diversion >= c_HAPPY_TH) && (r_hambre <= c_LVL_TWO))
                w_estado_nxt = c_FELIZ;
            else
                w_estado_nxt = c_NEUTRO;
            if (!r_test_active && !w_test_rel && (r_hold_cnt >= c_HOLD_M1))
                w_test_nxt = 1'b1;
        end
    end

    // Mood, change pulse and test-mode flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado        <= c_NEUTRO;
            r_estado_cambio <= 1'b0;
            r_test_active   <= 1'b0;
        end else begin
            r_estado        <= w_estado_nxt;
            r_estado_cambio <= (w_estado_nxt != r_estado);
            r_test_active   <= w_test_nxt;
        end
    end

    assign bus.estado        = r_estado;
    assign bus.hambre        = r_hambre;
    assign bus.diversion     = r_diversion;
    assign bus.tick          = w_tick;
    assign bus.estado_cambio = r_estado_cambio;
    assign bus.test_active   = r_test_active;

endmodule
`default_nettype wire

// File: tb/tb_tamagotchi_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tamagotchi_core
//  Description : Directed self-checking bench for tamagotchi_core with a
//                4-cycle tick; cycle numbers count from reset release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tamagotchi_core;

    localparam logic [31:0] NEUTRO = 0, FELIZ = 1, TRISTE = 2,
                            CANSADO = 3, HAMBRIENTO = 4, MUERTO = 5;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   passed;
    int   fails;

    tamagotchi_core_if #(.LVL_W(3)) bus ();

    tamagotchi_core #(
        .TICK_CYCLES     (4),
        .LVL_W           (3),
        .LVL_MAX         (5),
        .HUNGRY_TH       (4),
        .SAD_TH          (2),
        .HAPPY_TH        (4),
        .DECAY_TICKS     (2),
        .TIRED_TICKS     (2),
        .DEATH_TICKS     (3),
        .TEST_HOLD_TICKS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_lv(input string tag, input logic [31:0] est,
                            input logic [31:0] h, input logic [31:0] d,
                            input logic [31:0] chg);
        check({tag, "_estado"},    32'(bus.estado),        est);
        check({tag, "_hambre"},    32'(bus.hambre),        h);
        check({tag, "_diversion"}, 32'(bus.diversion),     d);
        check({tag, "_cambio"},    32'(bus.estado_cambio), chg);
    endtask

    task automatic check_reset(input string tag);
        check_lv(tag, NEUTRO, 1, 5, 0);
        check({tag, "_tick"},   32'(bus.tick),        0);
        check({tag, "_testac"}, 32'(bus.test_active), 0);
    endtask

    // Advance to cycle n, sampling 1 time unit after the rising edge
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        logic [31:0] seq [6];
        seq = '{TRISTE, CANSADO, HAMBRIENTO, MUERTO, NEUTRO, FELIZ};
        total = 0; passed = 0; fails = 0; cyc = 0;
        reset = 1'b1;
        bus.test_n = 1'b1; bus.feed_n = 1'b1; bus.play_n = 1'b1;
        bus.ultrasonido_n = 1'b1; bus.ruido_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        reset = 1'b0;
        cyc = 0;

        // Idle behaviour: first tick, happy, decay
        check("c0_tick", 32'(bus.tick), 0);
        goto(3);  check("c3_tick", 32'(bus.tick), 1);
                  check("c3_estado", 32'(bus.estado), NEUTRO);
        goto(4);  check_lv("c4", FELIZ, 1, 5, 1);
                  check("c4_tick", 32'(bus.tick), 0);
        goto(5);  check("c5_cambio", 32'(bus.estado_cambio), 0);
        goto(8);  check_lv("c8", FELIZ, 2, 4, 0);
        goto(16); check_lv("c16", FELIZ, 3, 3, 0);
        goto(20); check_lv("c20", NEUTRO, 3, 3, 1);
        goto(24); check_lv("c24", NEUTRO, 4, 2, 0);

        // Hungry, then feed
        goto(28); check_lv("c28", HAMBRIENTO, 4, 2, 1);
        bus.feed_n = 1'b0;
        goto(30); check("c30_hambre", 32'(bus.hambre), 4);
        bus.feed_n = 1'b1;
        goto(31); check("c31_hambre", 32'(bus.hambre), 2);
                  check("c31_tick", 32'(bus.tick), 1);
        goto(32); check_lv("c32", TRISTE, 3, 1, 1);

        // Feed + play together, sensor held for two ticks
        bus.feed_n = 1'b0; bus.play_n = 1'b0; bus.ultrasonido_n = 1'b0;
        goto(34); bus.feed_n = 1'b1; bus.play_n = 1'b1;
        goto(35); check("c35_hambre", 32'(bus.hambre), 1);
                  check("c35_diversion", 32'(bus.diversion), 3);
        goto(36); check_lv("c36", NEUTRO, 1, 3, 1);
        goto(40); check_lv("c40", CANSADO, 2, 2, 1);
        bus.ultrasonido_n = 1'b1;
        goto(44); check_lv("c44", TRISTE, 2, 2, 1);

        // Sustained critical fun level leads to death
        goto(48); check_lv("c48", TRISTE, 3, 1, 0);
        goto(56); check_lv("c56", TRISTE, 4, 1, 0);
        goto(60); check_lv("c60", MUERTO, 4, 1, 1);
        bus.feed_n = 1'b0; bus.play_n = 1'b0;
        goto(62); bus.feed_n = 1'b1; bus.play_n = 1'b1;
        goto(63); check("c63_hambre", 32'(bus.hambre), 4);
                  check("c63_diversion", 32'(bus.diversion), 1);
        goto(64); check_lv("c64", MUERTO, 4, 1, 0);

        // Reset mid-operation, then hold test button from release
        reset = 1'b1;
        goto(65); check_reset("rst2");
        reset = 1'b0; bus.test_n = 1'b0;
        cyc = 0;
        goto(4);  check_lv("t4", FELIZ, 1, 5, 1);
        goto(11); check("t11_testac", 32'(bus.test_active), 0);
        goto(12); check_lv("t12", FELIZ, 2, 4, 0);
                  check("t12_testac", 32'(bus.test_active), 1);
        for (int k = 0; k < 6; k++) begin
            goto(16 + 4 * k);
            check_lv($sformatf("t%0d", 16 + 4 * k), seq[k], 2, 4, 1);
            check($sformatf("t%0d_testac", 16 + 4 * k),
                  32'(bus.test_active), 1);
        end
        bus.test_n = 1'b1;
        goto(38); check("t38_testac", 32'(bus.test_active), 1);
                  check("t38_estado", 32'(bus.estado), FELIZ);
        goto(39); check("t39_testac", 32'(bus.test_active), 0);
                  check_lv("t39", NEUTRO, 2, 4, 1);
        goto(40); check_lv("t40", FELIZ, 3, 3, 1);
        goto(44); check("t44_estado", 32'(bus.estado), NEUTRO);

        // Feed landing in a decay cycle; play presses clamp at the top
        goto(45); bus.feed_n = 1'b0;
        goto(47); bus.feed_n = 1'b1;
                  check("t47_hambre", 32'(bus.hambre), 3);
                  check("t47_tick", 32'(bus.tick), 1);
        goto(48); check_lv("t48", NEUTRO, 2, 2, 0);
        bus.play_n = 1'b0;
        goto(50); bus.play_n = 1'b1;
        goto(51); check("t51_diversion", 32'(bus.diversion), 4);
        goto(52); bus.play_n = 1'b0;
        goto(54); bus.play_n = 1'b1;
        goto(55); check("t55_diversion", 32'(bus.diversion), 5);
        goto(56); check("t56_diversion", 32'(bus.diversion), 4);
        bus.play_n = 1'b0;
        goto(58); bus.play_n = 1'b1;
        goto(59); check("t59_diversion", 32'(bus.diversion), 5);
        goto(60); bus.play_n = 1'b0;
        goto(62); bus.play_n = 1'b1;
        goto(63); check("t63_diversion", 32'(bus.diversion), 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
